// File: rtl/seven_seg_driver.sv
// Three-digit multiplexed 7-segment driver: sequential double-dabble byte-to-BCD
// converter plus a free-running refresh scanner. Optional macro LEADING_ZERO_BLANK_EN.
module seven_seg_driver #(
  parameter int REFRESH_DIV = 16
) (
  input  logic        CLK,
  input  logic        nCLR,
  input  logic [7:0]  value,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t        state, state_next;
  logic [7:0]    shadow;
  logic [19:0]   sr;
  logic [2:0]    cnt;
  logic [11:0]   bcd_q;
  logic [RW-1:0] ref_cnt;
  logic [1:0]    dsel;
  logic [3:0]    digit;
  logic          blank;

  // One double-dabble iteration: correct each BCD nibble, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'h3F;
      4'd1:    encode = 7'h06;
      4'd2:    encode = 7'h5B;
      4'd3:    encode = 7'h4F;
      4'd4:    encode = 7'h66;
      4'd5:    encode = 7'h6D;
      4'd6:    encode = 7'h7D;
      4'd7:    encode = 7'h07;
      4'd8:    encode = 7'h7F;
      4'd9:    encode = 7'h6F;
      default: encode = 7'h00;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (value != shadow) state_next = SHIFT;
      SHIFT:   if (cnt == 3'd7) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Value changes while converting are ignored; IDLE recaptures any still-differing value.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      shadow <= 8'd0;
      sr     <= 20'd0;
      cnt    <= 3'd0;
      bcd_q  <= 12'd0;
    end else begin
      case (state)
        IDLE: begin
          if (value != shadow) begin
            shadow <= value;
            sr     <= {12'd0, value};
            cnt    <= 3'd0;
          end
        end
        SHIFT: begin
          sr  <= dabble_step(sr);
          cnt <= cnt + 3'd1;
        end
        LOAD:    bcd_q <= sr[19:8];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      ref_cnt <= '0;
      dsel    <= 2'd0;
    end else if (ref_cnt == REF_MAX) begin
      ref_cnt <= '0;
      dsel    <= (dsel == 2'd2) ? 2'd0 : dsel + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + RW'(1);
    end
  end

  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    an    = 3'b111;
    case (dsel)
      2'd0: begin
        digit = bcd_q[3:0];
        an    = 3'b110;
      end
      2'd1: begin
        digit = bcd_q[7:4];
        an    = 3'b101;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
`endif
      end
      2'd2: begin
        digit = bcd_q[11:8];
        an    = 3'b011;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (bcd_q[11:8] == 4'd0);
`endif
      end
      default: ;
    endcase
    seg = blank ? 7'h00 : encode(digit);
  end

  assign bcd  = bcd_q;
  assign busy = (state != IDLE);

endmodule
